bist_misr_analyzer: RTL and testbench
=====================================

# bist_misr_analyzer

Output response analyzer for the 8-bit BIST path. Compresses the circuit-under-test response stream into a signature with a Multiple-Input Signature Register (MISR). The MISR uses the same feedback polynomial as the pattern generator. After a programmed number of accepted beats, it compares the signature against a golden value and reports pass/fail. It sits at the CUT output, the other end of the BIST pattern path.

## Interface
- `N_PATTERNS`, default 255: response beats compressed per run; legal range 1..65535.
- `SEED`, default 8'h00: signature value loaded at run start.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
  - One clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- `din_valid`  in  1  response beat is present on `din`.
- `din`  in  8  CUT response.
- `golden`  in  8  expected signature; sampled on the accepted `start`.
- `busy`  out  1  high in RUN and CHECK.
- `done`  out  1  high in DONE; held until the next accepted `start` or `reset`.
- `pass`  out  1  valid while `done`=1; 1 = signature matched `golden`.
- `signature`  out  8  live MISR contents.
- `count`  out  16  beats accepted in the current run.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + `start`:
  - go to RUN;
  - `signature` <= `SEED`, `count` <= 0;
  - `golden_q` <= `golden`;
  - `done` <= 0, `pass` <= 0.
- RUN + `din_valid`: compress, `count` <= `count`+1.
- RUN without `din_valid`: everything holds; gaps are unlimited.
- RUN + `din_valid` with `count` == `N_PATTERNS`-1: compress, then go to CHECK.
- CHECK: `pass` <= (`signature` == `golden_q`), `done` <= 1, go to DONE. CHECK is always exactly one cycle.
- DONE: `signature`, `count` and `pass` hold.
- Compression rule (Galois form, tap mask 8'h33, i.e. bits 0,1,4,5):
  - `s_next[0]` = `d[0]` ^ `s[7]`;
  - `s_next[i]` = `s[i-1]` ^ (`TAP[i]` & `s[7]`) ^ `d[i]` for i=1..7.
- With `d`=0, the MISR sequence equals the pattern generator's sequence.
- Ignored inputs:
  - `din_valid` outside RUN;
  - `start` while `busy` (no restart, no state change);
  - a `start` coinciding with a `din_valid` in IDLE/DONE (only `start` acts).
- `count` is 16-bit and never wraps, because the run ends at `N_PATTERNS`.
- `reset` (any state, mid-run included) takes precedence over all inputs in that cycle.
  - State to IDLE.
  - `signature` = `SEED`, `count` = 0, `golden_q` = 0.
  - `busy` = 0, `done` = 0, `pass` = 0.

## Timing
- All outputs are registered. `busy` is decoded from the registered state.
- `start` accepted at edge t: `busy` = 1 from t.
  - A beat is accepted at edge t+1 at the earliest.
- Last beat accepted at edge k: state is CHECK after k.
  - `done` = 1 and `pass` are valid after edge k+1.
  - `busy` drops after k+1.
- Minimum run length: `N_PATTERNS`+2 cycles from `start` to `done`.
- Back-to-back runs: `start` in the first DONE cycle is accepted. `done` clears at that same edge.

## Structure
- Shared package `bist_pkg`:
  - `BIST_W` = 8;
  - `BIST_TAPS` = 8'h33, also used by the pattern generator;
  - FSM state enum `misr_state_t` (IDLE, RUN, CHECK, DONE).
- Sub-module `misr_core`: 8-bit register with load (`SEED`), enable and compress. It takes `BIST_TAPS` from the package.
- The top module holds the FSM, the beat counter, `golden_q` and the comparator.

## Test plan
- Reset-then-idle: hold `reset` 2 cycles, then toggle `din_valid`/`din` with no `start`.
  - Required: `signature` = 8'h00, `count` = 0, `busy`/`done`/`pass` = 0 throughout.
- `N_PATTERNS`=2, `golden`=8'h78, beats 8'hA5 then 8'h01.
  - Required: `signature` 8'hA5 after beat 1 and 8'h78 after beat 2; `done`=1, `pass`=1.
- Same run with beat 2 = 8'h00 (single-bit error).
  - Required: `signature` = 8'h79, `done`=1, `pass`=0.
- `N_PATTERNS`=3, all beats 8'h00 with idle gaps of 0, 1 and 5 cycles.
  - Required: `signature` 8'h00, `count` = 3, `pass`=1 with `golden`=8'h00.
  - Required: `done` exactly 2 edges after the third beat.
- Ignored `start`: pulse `start` during RUN and `din_valid` during DONE.
  - Required: neither `count` nor `signature` changes.
- Mid-run reset: assert `reset` after 1 of 2 beats.
  - Required: IDLE, `signature` 8'h00, `count` 0, `busy` 0.
  - Then a fresh run with 8'hA5, 8'h01 still yields 8'h78 and `pass`=1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: datapath width, the LFSR/MISR feedback taps and the analyzer FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bist_pkg;

  localparam int BIST_W = 8;

  // Galois tap mask (bits 0,1,4,5). The pattern generator uses the same polynomial.
  localparam logic [BIST_W-1:0] BIST_TAPS = 8'h33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } misr_state_t;

endpackage

// File: rtl/misr_core.sv
// 8-bit Galois MISR: loads SEED on load, folds d into the register on en.
// Latency: one cycle; the register updates on the edge where en is sampled high.
// Backpressure: none; en is qualified by the caller, and the register holds when en is low.
module misr_core
  import bist_pkg::*;
#(
  parameter logic [BIST_W-1:0] SEED = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [BIST_W-1:0] d,
  output logic [BIST_W-1:0] sig
);

  logic [BIST_W-1:0] sig_next;

  // Shift up one bit, feed the MSB back through the tap mask, and fold in the response.
  // TAP[0] is set, so bit 0 receives d[0] ^ s[7] as the polynomial requires.
  always_comb begin
    sig_next = {sig[BIST_W-2:0], 1'b0} ^ (BIST_TAPS & {BIST_W{sig[BIST_W-1]}}) ^ d;
  end

  // Signature register: reset and load both return to SEED, otherwise compress when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// BIST response analyzer: compresses N_PATTERNS accepted beats into a MISR signature and compares it with golden.
// Latency: done and pass are valid two edges after the last beat is accepted (RUN -> CHECK -> DONE).
// Backpressure: none; beats are accepted on any RUN cycle with din_valid, and gaps between beats are unlimited.
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int                N_PATTERNS = 255,
  parameter logic [BIST_W-1:0] SEED       = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              din_valid,
  input  logic [BIST_W-1:0] din,
  input  logic [BIST_W-1:0] golden,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [BIST_W-1:0] signature,
  output logic [15:0]       count
);

  localparam logic [15:0] LAST_IDX = 16'(N_PATTERNS - 1);

  misr_state_t       state, state_next;
  logic [BIST_W-1:0] golden_q;
  logic              start_ok;
  logic              beat;
  logic              last_beat;

  // A start is honoured only when no run is in flight; beats count only while running.
  always_comb begin
    start_ok  = start && ((state == IDLE) || (state == DONE));
    beat      = din_valid && (state == RUN);
    last_beat = beat && (count == LAST_IDX);
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok)  state_next = RUN;
      RUN:     if (last_beat) state_next = CHECK;
      CHECK:                  state_next = DONE;
      DONE:    if (start_ok)  state_next = RUN;
      default:                state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign busy = (state == RUN) || (state == CHECK);

  misr_core #(
    .SEED(SEED)
  ) u_misr (
    .clk  (clk),
    .reset(reset),
    .load (start_ok),
    .en   (beat),
    .d    (din),
    .sig  (signature)
  );

  // Beat counter and golden capture; both restart on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      golden_q <= '0;
    end else if (start_ok) begin
      count    <= '0;
      golden_q <= golden;
    end else if (beat) begin
      count    <= count + 16'd1;
    end
  end

  // Verdict: the CHECK cycle sees the signature including the last beat; the result holds through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (start_ok) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == CHECK) begin
      done <= 1'b1;
      pass <= (signature == golden_q);
    end
  end

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Self-checking bench for bist_misr_analyzer: directed cases plus randomized runs against a transaction-level model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_bist_misr_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start2, start3, din_valid;
  logic [7:0] din, golden;
  logic       busy2, done2, pass2, busy3, done3, pass3;
  logic [7:0] sig2, sig3;
  logic [15:0] cnt2, cnt3;

  bist_misr_analyzer #(.N_PATTERNS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .din_valid(din_valid), .din(din),
    .golden(golden), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .count(cnt2)
  );

  bist_misr_analyzer #(.N_PATTERNS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .din_valid(din_valid), .din(din),
    .golden(golden), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .count(cnt3)
  );

  int vectors = 0;
  int miscompares = 0;

  // Outputs of the instance currently under test (sel: 0 -> N=2, 1 -> N=3).
  logic       sel = 1'b0;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_sig;
  logic [15:0] o_cnt;
  always_comb begin
    o_busy = sel ? busy3 : busy2;
    o_done = sel ? done3 : done2;
    o_pass = sel ? pass3 : pass2;
    o_sig  = sel ? sig3  : sig2;
    o_cnt  = sel ? cnt3  : cnt2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference compression: multiply the signature by x over GF(2) modulo the tap polynomial, then add the response.
  function automatic logic [7:0] fold(input logic [7:0] s, input logic [7:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = (v - 256) ^ 'h33;
    return 8'(v) ^ d;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_all(input string tag);
    check({tag, "_busy2"}, busy2, 0);
    check({tag, "_done2"}, {done2, pass2}, 0);
    check({tag, "_sig2"},  sig2, 8'h00);
    check({tag, "_cnt2"},  cnt2, 0);
    check({tag, "_busy3"}, busy3, 0);
    check({tag, "_sig3"},  sig3, 8'h00);
    check({tag, "_cnt3"},  cnt3, 0);
  endtask

  // One complete run on instance s: beats with gaps before each, optional stray starts in gaps,
  // then verification of CHECK/DONE timing, verdict and hold behaviour in DONE.
  task automatic do_run(input logic s, input logic [7:0] beats[$], input int gaps[$],
                        input logic [7:0] gold, input int hold_cycles, input string tag);
    logic [7:0] exp_sig;
    sel = s;
    golden = gold;
    if (s) start3 = 1'b1; else start2 = 1'b1;
    din_valid = 1'($urandom_range(0, 1));  // coincident beat must be ignored
    din = 8'($urandom);
    tick();
    start2 = 1'b0; start3 = 1'b0;
    golden = 8'($urandom);                 // golden is sampled only at start
    exp_sig = 8'h00;
    check({tag, "_start_busy"}, o_busy, 1);
    check({tag, "_start_done"}, {o_done, o_pass}, 0);
    check({tag, "_start_sig"}, o_sig, exp_sig);
    check({tag, "_start_cnt"}, o_cnt, 0);
    for (int i = 0; i < beats.size(); i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        din_valid = 1'b0;
        din = 8'($urandom);
        if (s) start3 = 1'($urandom_range(0, 1)); else start2 = 1'($urandom_range(0, 1));
        tick();
        start2 = 1'b0; start3 = 1'b0;
        check({tag, "_gap_sig"}, o_sig, exp_sig);
        check({tag, "_gap_cnt"}, o_cnt, i);
      end
      din_valid = 1'b1;
      din = beats[i];
      tick();
      exp_sig = fold(exp_sig, beats[i]);
      check({tag, "_beat_sig"}, o_sig, exp_sig);
      check({tag, "_beat_cnt"}, o_cnt, i + 1);
    end
    din_valid = 1'b0;
    check({tag, "_check_busy"}, o_busy, 1);
    check({tag, "_check_done"}, o_done, 0);
    tick();
    check({tag, "_done"}, o_done, 1);
    check({tag, "_done_busy"}, o_busy, 0);
    check({tag, "_pass"}, o_pass, (exp_sig == gold));
    check({tag, "_final_sig"}, o_sig, exp_sig);
    check({tag, "_final_cnt"}, o_cnt, beats.size());
    for (int h = 0; h < hold_cycles; h++) begin
      din_valid = 1'b1;
      din = 8'($urandom);
      tick();
      din_valid = 1'b0;
      check({tag, "_hold"}, {o_done, o_pass, o_busy, o_sig, o_cnt},
            {1'b1, (exp_sig == gold), 1'b0, exp_sig, 16'(beats.size())});
    end
  endtask

  initial begin
    logic [7:0] bq[$];
    int         gq[$];
    logic [7:0] e;
    int         n;
    reset = 1'b1; start2 = 1'b0; start3 = 1'b0; din_valid = 1'b0; din = 8'h00; golden = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_idle_all("reset");

    // Idle with traffic but no start: nothing moves.
    for (int i = 0; i < 6; i++) begin
      din_valid = ~din_valid;
      din = 8'($urandom);
      tick();
      check_idle_all("idle");
    end
    din_valid = 1'b0;

    // Known-answer runs.
    bq = '{8'hA5, 8'h01}; gq = '{0, 0};
    do_run(1'b0, bq, gq, 8'h78, 0, "kat_pass");
    check("kat_sig78", sig2, 8'h78);
    check("kat_pass1", pass2, 1);
    bq = '{8'hA5, 8'h00}; gq = '{0, 2};
    do_run(1'b0, bq, gq, 8'h78, 2, "kat_err");   // back-to-back start in first DONE cycle
    check("kat_sig79", sig2, 8'h79);
    check("kat_pass0", pass2, 0);

    // Zero stream with gaps 0, 1, 5 on the 3-beat instance.
    bq = '{8'h00, 8'h00, 8'h00}; gq = '{0, 1, 5};
    do_run(1'b1, bq, gq, 8'h00, 3, "zero_gap");
    check("zero_cnt3", cnt3, 3);
    check("zero_pass", pass3, 1);

    // Mid-run reset after one of two beats.
    sel = 1'b0;
    start2 = 1'b1; golden = 8'h78; tick(); start2 = 1'b0;
    din_valid = 1'b1; din = 8'hA5; tick(); din_valid = 1'b0;
    check("mid_sig_before", sig2, 8'hA5);
    reset = 1'b1; start2 = 1'b1; din_valid = 1'b1; tick();
    reset = 1'b0; start2 = 1'b0; din_valid = 1'b0;
    check_idle_all("midrst");
    bq = '{8'hA5, 8'h01}; gq = '{1, 0};
    do_run(1'b0, bq, gq, 8'h78, 1, "after_rst");
    check("after_rst_pass", pass2, 1);

    // Randomized runs on both instances; golden is either the true signature or a random value.
    for (int r = 0; r < 24; r++) begin
      logic s;
      s = 1'($urandom_range(0, 1));
      n = s ? 3 : 2;
      bq = {}; gq = {};
      e = 8'h00;
      for (int i = 0; i < n; i++) begin
        bq.push_back(8'($urandom));
        gq.push_back($urandom_range(0, 3));
        e = fold(e, bq[i]);
      end
      do_run(s, bq, gq, ($urandom_range(0, 1) != 0) ? e : 8'($urandom), $urandom_range(0, 2), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule
